// File: rtl/lighthouse_pulse_gen_pkg.sv
// Shared lighthouse constants, FSM encoding and sync-length helper.
package lighthouse_pulse_gen_pkg;

    // Timing constants for a 50 MHz clock.
    localparam int unsigned LH_SYNC_BASE = 3125;     // 62.5 us base sync pulse
    localparam int unsigned LH_SYNC_STEP = 521;      // 10.42 us per code unit
    localparam int unsigned LH_PERIOD    = 416_667;  // 8.333 ms sweep period
    localparam int unsigned LH_CNT_W     = 19;

    typedef logic [LH_CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StGap,
        StSweep,
        StTail
    } lh_state_e;

    // Sync pulse length in clocks for a 3-bit code {skip, data, axis}.
    function automatic cnt_t sync_clocks(input int unsigned base, input int unsigned step,
                                         input logic [2:0] code);
        return cnt_t'(base) + cnt_t'(step) * cnt_t'(code);
    endfunction

endpackage

// File: rtl/ootx_serializer.sv
// OOTX payload shifter: holds one 32-bit word and hands out one bit per period, MSB first.
module ootx_serializer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] word,
    input  logic        valid,
    output logic        ready,
    output logic        data_bit
);

    logic [31:0] shift_q, shift_d, shift_eff;
    logic [5:0]  left_q, left_d, left_eff;
    logic        load;

    assign ready = (left_q == 6'd0);
    assign load  = valid & ready;

    // A load in the same clock as a period start wins, so the new word's MSB goes out first.
    assign shift_eff = load ? word : shift_q;
    assign left_eff  = load ? 6'd32 : left_q;
    assign data_bit  = shift_eff[31] & (left_eff != 6'd0);

    // Next state: consume one bit per period start while bits remain.
    always_comb begin
        shift_d = shift_eff;
        left_d  = left_eff;
        if (start && (left_eff != 6'd0)) begin
            shift_d = {shift_eff[30:0], 1'b0};
            left_d  = left_eff - 6'd1;
        end
    end

    // Shift register and remaining-bit counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            left_q  <= '0;
        end else begin
            shift_q <= shift_d;
            left_q  <= left_d;
        end
    end

endmodule

// File: rtl/lighthouse_pulse_gen.sv
// Lighthouse base-station emulator: sync pulse + optional sweep pulse every period.
module lighthouse_pulse_gen
    import lighthouse_pulse_gen_pkg::*;
#(
    parameter int unsigned CLK_SPEED = 50_000_000,
    parameter int unsigned SYNC_BASE = LH_SYNC_BASE,
    parameter int unsigned SYNC_STEP = LH_SYNC_STEP,
    parameter int unsigned PERIOD    = LH_PERIOD
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable_i,
    input  logic        skip_i,
    input  logic [18:0] sweep_delay_i,
    input  logic [9:0]  sweep_width_i,
    input  logic [31:0] data_word_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic        envelope_o,
    output logic        sync_o,
    output logic        axis_o,
    output logic        cfg_err_o
);

    localparam cnt_t LAST = cnt_t'(PERIOD - 1);

    // CLK_SPEED only documents the clock the constants were sized for.
    logic unused_clk_speed;
    assign unused_clk_speed = (CLK_SPEED != 0);

    lh_state_e   state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        axis_q, axis_d;
    cnt_t        sync_last_q, gap_last_q, sweep_last_q;
    logic        sweep_on_q, cfg_bad_q;

    logic        wrap, period_start, data_bit;
    logic [2:0]  code;
    cnt_t        sync_len;
    logic [19:0] sweep_end_x;
    logic        timing_bad, sweep_req;

    ootx_serializer u_ootx (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (period_start),
        .word     (data_word_i),
        .valid    (data_valid_i),
        .ready    (data_ready_o),
        .data_bit (data_bit)
    );

    assign wrap         = (state_q == StTail) && (cnt_q == LAST);
    assign period_start = enable_i && ((state_q == StIdle) || wrap);

    // First period out of idle uses axis 0; back-to-back periods alternate.
    assign axis_d = !period_start      ? axis_q :
                    (state_q == StIdle) ? 1'b0   : ~axis_q;

    assign code        = {skip_i, data_bit, axis_d};
    assign sync_len    = sync_clocks(SYNC_BASE, SYNC_STEP, code);
    assign sweep_end_x = {1'b0, sweep_delay_i} + {10'b0, sweep_width_i};
    assign timing_bad  = (sweep_delay_i <= sync_len) || (sweep_end_x > {1'b0, LAST});
    assign sweep_req   = !skip_i && (sweep_width_i != 10'd0);

    // Latch the period's timing at period start; later input changes are ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_last_q  <= '0;
            gap_last_q   <= '0;
            sweep_last_q <= '0;
            sweep_on_q   <= 1'b0;
            cfg_bad_q    <= 1'b0;
        end else if (period_start) begin
            sync_last_q  <= sync_len - cnt_t'(1);
            gap_last_q   <= sweep_delay_i - cnt_t'(1);
            sweep_last_q <= cnt_t'(sweep_end_x - 20'd1);
            sweep_on_q   <= sweep_req && !timing_bad;
            cfg_bad_q    <= sweep_req && timing_bad;
        end
    end

    // Next-state logic: period counter and phase FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q != StIdle) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + cnt_t'(1);
        end
        unique case (state_q)
            StIdle:  if (period_start) state_d = StSync;
            StSync:  if (cnt_q == sync_last_q) state_d = StGap;
            StGap: begin
                if (!sweep_on_q) begin
                    state_d = StTail;
                end else if (cnt_q == gap_last_q) begin
                    state_d = StSweep;
                end
            end
            StSweep: if (cnt_q == sweep_last_q) state_d = StTail;
            StTail:  if (wrap) state_d = period_start ? StSync : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, counter and axis registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            axis_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            axis_q  <= axis_d;
        end
    end

    assign envelope_o = !((state_q == StSync) || (state_q == StSweep));
    assign sync_o     = (state_q == StSync) && (cnt_q == '0);
    assign cfg_err_o  = (state_q == StSync) && (cnt_q == cnt_t'(1)) && cfg_bad_q;
    assign axis_o     = axis_q;

endmodule

// File: tb/tb_lighthouse_pulse_gen.sv
// Scoreboard bench for lighthouse_pulse_gen, run with shortened timing constants.
module tb_lighthouse_pulse_gen;

    localparam int BASE = 31;
    localparam int STEP = 5;
    localparam int PER  = 300;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable_i, skip_i, data_valid_i;
    logic [18:0] sweep_delay_i;
    logic [9:0]  sweep_width_i;
    logic [31:0] data_word_i;
    logic        data_ready_o, envelope_o, sync_o, axis_o, cfg_err_o;

    lighthouse_pulse_gen #(
        .CLK_SPEED (50_000_000),
        .SYNC_BASE (BASE),
        .SYNC_STEP (STEP),
        .PERIOD    (PER)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable_i      (enable_i),
        .skip_i        (skip_i),
        .sweep_delay_i (sweep_delay_i),
        .sweep_width_i (sweep_width_i),
        .data_word_i   (data_word_i),
        .data_valid_i  (data_valid_i),
        .data_ready_o  (data_ready_o),
        .envelope_o    (envelope_o),
        .sync_o        (sync_o),
        .axis_o        (axis_o),
        .cfg_err_o     (cfg_err_o)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int t;
        int len;
        bit is_sync;
        bit axis;
    } pulse_t;

    pulse_t env_q[$];
    int     err_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    bit     mon_en = 1'b0;

    // Reference model state: pending payload bits, axis of last period, idle flag.
    bit     m_bits[$];
    bit     m_axis = 1'b0;
    bit     m_idle = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load_bits(input logic [31:0] w);
        m_bits.delete();
        for (int i = 31; i >= 0; i--) m_bits.push_back(w[i]);
    endtask

    // Monitor: each envelope low pulse and cfg_err_o pulse is matched against the scoreboard.
    bit in_pulse = 1'b0;
    bit sync_fall, fall_axis;
    int fall_t, sync_hits;
    always @(negedge clock) begin : monitor
        pulse_t e;
        if (!mon_en) begin
            in_pulse = 1'b0;
        end else begin
            if (cfg_err_o) begin
                if (err_q.size() == 0) check("cfg_err unexpected", 1, 0);
                else check("cfg_err time", cyc, err_q.pop_front());
            end
            if (!envelope_o) begin
                if (!in_pulse) begin
                    in_pulse  = 1'b1;
                    fall_t    = cyc;
                    sync_hits = 0;
                    sync_fall = sync_o;
                    fall_axis = axis_o;
                end
                if (sync_o) sync_hits++;
            end else begin
                if (sync_o) check("sync_o outside pulse", 1, 0);
                if (in_pulse) begin
                    in_pulse = 1'b0;
                    if (env_q.size() == 0) begin
                        check("envelope pulse unexpected", fall_t, -1);
                    end else begin
                        e = env_q.pop_front();
                        check("pulse start", fall_t, e.t);
                        check("pulse length", cyc - fall_t, e.len);
                        check("sync_o count", sync_hits, int'(e.is_sync));
                        check("sync_o on first low", int'(sync_fall), int'(e.is_sync));
                        if (e.is_sync) check("axis", int'(fall_axis), int'(e.axis));
                    end
                end
            end
        end
    end

    // Drive one period; called at the negedge just before the period-start edge.
    task automatic period(input int mode);
        bit          skip, vld, bitv, gv;
        logic [31:0] w, gw;
        int          width, delay, code, slen, start;
        pulse_t      p;
        start = cyc + 1;
        skip  = 1'b0;
        vld   = ($urandom_range(0, 1) == 1);
        w     = $urandom;
        width = $urandom_range(1, 80);
        delay = $urandom_range(40, 260);
        case (mode)
            0: begin
                skip = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 5) == 0) width = 0;
            end
            5: begin width = 0; vld = 1'b0; end
            6: begin width = 0; vld = 1'b1; w = 32'h8000_0000; end
            7: begin width = 50; delay = 100; vld = 1'b0; end
            8: begin skip = 1'b1; width = 50; delay = 100; vld = 1'b0; end
            default: ;
        endcase
        m_axis = m_idle ? 1'b0 : !m_axis;
        m_idle = 1'b0;
        if (vld && (m_bits.size() == 0)) load_bits(w);
        bitv = (m_bits.size() != 0) ? m_bits.pop_front() : 1'b0;
        code = 4 * int'(skip) + 2 * int'(bitv) + int'(m_axis);
        slen = BASE + STEP * code;
        case (mode)
            1: delay = slen + 1;        // smallest legal delay
            2: delay = PER - 1 - width; // sweep ends on the last legal count
            3: delay = slen;            // delay equal to sync length is illegal
            4: delay = PER - width;     // one count past the legal end
            default: ;
        endcase
        p = '{start, slen, 1'b1, m_axis};
        env_q.push_back(p);
        if (!skip && width != 0) begin
            if (delay <= slen || delay + width > PER - 1) begin
                err_q.push_back(start + 1);
            end else begin
                p = '{start + delay, width, 1'b0, 1'b0};
                env_q.push_back(p);
            end
        end
        enable_i      = 1'b1;
        skip_i        = skip;
        sweep_delay_i = 19'(delay);
        sweep_width_i = 10'(width);
        data_valid_i  = vld;
        data_word_i   = w;
        @(negedge clock);
        check("data_ready", int'(data_ready_o), (m_bits.size() == 0) ? 1 : 0);
        // Scramble inputs mid-period; only a handshake may take effect.
        gv            = ($urandom_range(0, 3) == 0);
        gw            = $urandom;
        enable_i      = ($urandom_range(0, 1) == 1);
        skip_i        = ($urandom_range(0, 1) == 1);
        sweep_delay_i = 19'($urandom);
        sweep_width_i = 10'($urandom);
        data_valid_i  = gv;
        data_word_i   = gw;
        if (gv && (m_bits.size() == 0)) load_bits(gw);
        @(negedge clock);
        data_valid_i = 1'b0;
        repeat (PER - 2) @(negedge clock);
    endtask

    task automatic idle_gap(input int n);
        enable_i     = 1'b0;
        data_valid_i = 1'b0;
        repeat (n) @(negedge clock);
        m_idle = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " envelope_o"}, int'(envelope_o), 1);
        check({tag, " sync_o"}, int'(sync_o), 0);
        check({tag, " axis_o"}, int'(axis_o), 0);
        check({tag, " cfg_err_o"}, int'(cfg_err_o), 0);
        check({tag, " data_ready_o"}, int'(data_ready_o), 1);
    endtask

    initial begin
        reset_n       = 1'b0;
        enable_i      = 1'b0;
        skip_i        = 1'b0;
        sweep_delay_i = '0;
        sweep_width_i = '0;
        data_word_i   = '0;
        data_valid_i  = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clock);

        // Directed periods, then randomized ones with occasional idle gaps.
        period(5);
        idle_gap(4);
        period(6);
        period(5);
        period(7);
        period(3);
        period(8);
        period(1);
        period(2);
        period(4);
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 15) == 0) idle_gap($urandom_range(1, 20));
            period(0);
        end

        // Reset in the middle of a sweep pulse on an axis-1 period.
        idle_gap(3);
        period(7);
        mon_en        = 1'b0;
        m_axis        = !m_axis;
        enable_i      = 1'b1;
        skip_i        = 1'b0;
        sweep_delay_i = 19'd100;
        sweep_width_i = 10'd50;
        data_valid_i  = 1'b1;
        data_word_i   = $urandom;
        if (m_bits.size() == 0) load_bits(data_word_i);
        void'(m_bits.pop_front());
        @(negedge clock);
        data_valid_i = 1'b0;
        repeat (119) @(negedge clock);
        check("envelope in sweep", int'(envelope_o), 0);
        check("axis before reset", int'(axis_o), int'(m_axis));
        check("ready before reset", int'(data_ready_o), (m_bits.size() == 0) ? 1 : 0);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("async reset");
        m_bits.delete();
        env_q.delete();
        err_q.delete();
        m_idle = 1'b1;
        @(negedge clock);
        enable_i = 1'b0;
        reset_n  = 1'b1;
        repeat (2) @(negedge clock);
        mon_en = 1'b1;
        period(8);
        idle_gap(5);

        check("pulses left unobserved", env_q.size(), 0);
        check("cfg_err left unobserved", err_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lighthouse_pulse_gen.md
LIGHTHOUSE_PULSE_GEN -- requirements
Module: lighthouse_pulse_gen

Interface
REQ-001 Parameter CLK_SPEED, default 50_000_000, clock frequency in Hz; documentation only, timing constants below are fixed for 50 MHz.
REQ-002 Parameter SYNC_BASE, default 3125, clocks for the 62.5 us base sync pulse.
REQ-003 Parameter SYNC_STEP, default 521, clocks added per sync code unit (10.42 us).
REQ-004 Parameter PERIOD, default 416_667, clocks per sweep period (8.333 ms), i.e. 120 periods/s.
REQ-005 clock  input  1  single system clock, 50 MHz.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable_i  input  1  1 = generate periods; sampled only at period start.
REQ-008 skip_i  input  1  skip bit of sync code; 1 suppresses the sweep pulse of that period.
REQ-009 sweep_delay_i  input  19  clocks from period start to sweep-pulse start.
REQ-010 sweep_width_i  input  10  sweep-pulse length in clocks; 0 suppresses the sweep.
REQ-011 data_word_i  input  32  OOTX payload word, shifted out MSB first, one bit per period.
REQ-012 data_valid_i  input  1  data_word_i is valid.
REQ-013 data_ready_o  output  1  shift register empty; word is accepted on data_valid_i & data_ready_o.
REQ-014 envelope_o  output  1  active-low envelope line, same polarity as sensor E line (0 = light).
REQ-015 sync_o  output  1  one-clock pulse on the first clock of every sync pulse.
REQ-016 axis_o  output  1  axis of the current period.
REQ-017 cfg_err_o  output  1  one-clock pulse when the latched sweep timing is illegal.

Function
REQ-018 A 19-bit period counter SHALL run 0..PERIOD-1 and wrap to 0 while active; count 0 is period start.
REQ-019 At period start the block SHALL latch enable_i, skip_i, sweep_delay_i and sweep_width_i; mid-period input changes SHALL have no effect.
REQ-020 If the latched enable is 0, the FSM SHALL stay in IDLE, with envelope_o=1, the counter at 0 and axis unchanged; a period starts on the first clock enable_i=1 is seen.
REQ-021 FSM states: IDLE, SYNC, GAP, SWEEP, TAIL; IDLE->SYNC at period start; SYNC->GAP after sync length; GAP->SWEEP at count==sweep_delay; SWEEP->TAIL after sweep_width clocks; TAIL->SYNC at wrap, or TAIL->IDLE if enable_i=0 at wrap.
REQ-022 Sync code SHALL be code = 4*skip + 2*data_bit + axis; sync length = SYNC_BASE + SYNC_STEP*code clocks.
REQ-023 envelope_o SHALL be 0 for exactly the sync-length clocks starting at count 0, and 0 for exactly sweep_width clocks starting at count==sweep_delay; otherwise 1.
REQ-024 sync_o SHALL pulse high together with the first 0 clock of envelope_o in SYNC.
REQ-025 axis SHALL toggle at every period start after the first; the first period after reset or IDLE uses axis 0.
REQ-026 The sweep timing SHALL be illegal when sweep_delay <= sync length or sweep_delay + sweep_width > PERIOD-1; then the sweep is suppressed and cfg_err_o pulses at count 1.
REQ-027 skip=1 or sweep_width=0 SHALL take GAP->TAIL with no sweep and no cfg_err_o.
REQ-028 data_bit SHALL be the MSB of a 32-bit shift register, shifted left at every period start; a 6-bit counter tracks the bits remaining.
REQ-029 data_ready_o SHALL be 1 when the bit counter is 0; a handshake loads the word and sets the counter to 32.
REQ-030 When the register is empty at a period start, data_bit SHALL be 0 and the counter SHALL stay at 0.
REQ-031 A handshake at a period start SHALL take effect first, so that period sends bit 31 of the new word.

Reset
REQ-032 reset_n low SHALL asynchronously force: state IDLE, counter 0, envelope_o=1, sync_o=0, axis_o=0, cfg_err_o=0, shift register 0, bit counter 0, data_ready_o=1.
REQ-033 A reset mid-pulse SHALL release envelope_o to 1 immediately; after release, the first period starts at the first clock with enable_i=1.

Structure
REQ-034 SYNC_BASE, SYNC_STEP, PERIOD and the FSM state encoding SHALL reside in a shared lighthouse package, which the sensor decoder also uses.
REQ-035 The OOTX shift register and handshake SHALL be a sub-module ootx_serializer; the rest is a single module.

Verification
REQ-036 skip=0, axis 0, empty data -> envelope_o low exactly 3125 clocks from count 0; sync_o high for exactly 1 clock.
REQ-037 Word 0x80000000 loaded, second period (axis 1) -> first period low 3125+2*521=4167 clocks; second period 3125+1*521=3646 clocks.
REQ-038 delay=100000, width=500 -> envelope_o low for counts 100000..100499 and high at 100500; next sync starts at count 416667 (wrap).
REQ-039 delay=3000 -> cfg_err_o pulse at count 1, no sweep pulse, sync unaffected.
REQ-040 skip=1 -> sync length 3125+4*521=5209, no sweep; reset_n low at count 50000 of a sweep -> envelope_o=1 within the same clock, all outputs at reset values.
